// File: rtl/cnn_core_if.sv
// ---------------------------------------------------------------------------
// cnn_core_if
// Bundles the image, weights and biases consumed by cnn_core together with the
// class scores it produces.
//
// Signals (all signed Q16.16 words):
//   input_data                    [input_size*input_size]          image, row-major
//   conv_filter_weight            [filters][K*K]                   kernel taps, row-major
//   cnn_filter_bias               [filters]                        per-filter bias
//   fully_connected_layer_weights [outputs][fc_num_inputs]         FC matrix
//   fully_connected_layer_bias    [outputs]                        per-output bias
//   fully_connected_layer_output  [outputs]                        registered scores
//
// Handshake: there is no valid/ready pair. The master holds every input word
// stable from reset release until the core reports DONE; the scores are final
// and stay constant once DONE is reached, until the next reset.
//
// Modports: master = source of the operands / sink of the scores,
//           slave  = cnn_core.
// ---------------------------------------------------------------------------
interface cnn_core_if #(
    parameter int input_size                 = 28,
    parameter int conv_filter_size           = 7,
    parameter int conv_num_filters           = 16,
    parameter int fully_connected_num_layers = 10,
    parameter int fc_num_inputs              = 256
);
    logic signed [31:0] input_data [input_size*input_size];
    logic signed [31:0] conv_filter_weight [conv_num_filters][conv_filter_size*conv_filter_size];
    logic signed [31:0] cnn_filter_bias [conv_num_filters];
    logic signed [31:0] fully_connected_layer_weights [fully_connected_num_layers][fc_num_inputs];
    logic signed [31:0] fully_connected_layer_bias [fully_connected_num_layers];
    logic signed [31:0] fully_connected_layer_output [fully_connected_num_layers];

    modport master (
        output input_data, conv_filter_weight, cnn_filter_bias,
        output fully_connected_layer_weights, fully_connected_layer_bias,
        input  fully_connected_layer_output
    );

    modport slave (
        input  input_data, conv_filter_weight, cnn_filter_bias,
        input  fully_connected_layer_weights, fully_connected_layer_bias,
        output fully_connected_layer_output
    );
endinterface

// File: rtl/cnn_core.sv
// ---------------------------------------------------------------------------
// cnn_core
// Sequential single-MAC CNN: convolution + bias + ReLU, max pooling, flatten
// and a fully connected layer, all in signed Q16.16.
//
// Ports:
//   clk     - clock, all state changes on the rising edge
//   rstb    - synchronous active-high reset; aborts any computation
//   bus     - cnn_core_if.slave: operands in, registered class scores out
//   state_o - current FSM state (0 IDLE, 1 CONV, 2 POOL, 3 FC, 4 DONE)
//
// Schedule: IDLE (1 cycle) -> CONV (K*K MACs + 1 finalize per output,
// filter-major, then row, then column) -> POOL (1 pooled value per cycle)
// -> FC (N MACs + 1 finalize per output) -> DONE (holds forever).
// ---------------------------------------------------------------------------
module cnn_core #(
    parameter int input_size                 = 28,
    parameter int conv_filter_size           = 7,
    parameter int conv_num_filters           = 16,
    parameter int conv_stride                = 3,
    parameter int pooling_size               = 2,
    parameter int fully_connected_num_layers = 10
) (
    input  logic       clk,
    input  logic       rstb,
    cnn_core_if.slave  bus,
    output logic [2:0] state_o
);
    localparam int K  = conv_filter_size;
    localparam int S  = conv_stride;
    localparam int IS = input_size;
    localparam int NF = conv_num_filters;
    localparam int PS = pooling_size;
    localparam int NL = fully_connected_num_layers;
    localparam int C  = (IS - K) / S + 1;
    localparam int CC = C * C;
    localparam int P  = (C - PS) / PS + 1;
    localparam int N  = NF * P * P;

    localparam int IN_W  = (IS * IS > 1) ? $clog2(IS * IS) : 1;
    localparam int TAP_W = (K * K > 1) ? $clog2(K * K) : 1;
    localparam int F_W   = (NF > 1) ? $clog2(NF) : 1;
    localparam int CM_W  = (NF * CC > 1) ? $clog2(NF * CC) : 1;
    localparam int PM_W  = (N > 1) ? $clog2(N) : 1;
    localparam int J_W   = (NL > 1) ? $clog2(NL) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CONV = 3'd1,
        S_POOL = 3'd2,
        S_FC   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state_q, state_d;

    // f_q/r_q/c_q walk filter/row/column in CONV and filter/pooled row/pooled
    // column in POOL; in FC f_q is the output index j. idx_q is the flat
    // pooled index in POOL and the MAC input index i in FC.
    logic [31:0] f_q, r_q, c_q, kr_q, kc_q, idx_q;
    logic signed [63:0] acc_q, prod;

    logic signed [31:0] out_q      [NL];
    logic signed [31:0] conv_mem_q [NF*CC];
    logic signed [31:0] pool_mem_q [N];

    logic signed [31:0] mul_a, mul_b, scaled, conv_val, relu_val, fc_val, pool_max;
    logic [CM_W-1:0]    cm_wr, cm_rd;
    logic               conv_mac, conv_fin, conv_done, pool_done, fc_mac, fc_done;

    always_comb begin
        mul_a    = '0;
        mul_b    = '0;
        conv_val = '0;
        fc_val   = '0;
        pool_max = '0;
        cm_wr    = '0;
        cm_rd    = '0;
        scaled   = 32'(acc_q >>> 16);

        // kr_q reaching K marks the finalize cycle of a conv output;
        // idx_q reaching N marks the finalize cycle of an FC output.
        conv_mac = (state_q == S_CONV) && (kr_q < K);
        conv_fin = (state_q == S_CONV) && (kr_q == K);
        fc_mac   = (state_q == S_FC) && (idx_q < N);

        if (conv_mac) begin
            mul_a = bus.input_data[IN_W'((r_q * S + kr_q) * IS + c_q * S + kc_q)];
            mul_b = bus.conv_filter_weight[F_W'(f_q)][TAP_W'(kr_q * K + kc_q)];
        end
        if (conv_fin) begin
            conv_val = scaled + bus.cnn_filter_bias[F_W'(f_q)];
            cm_wr    = CM_W'(f_q * CC + r_q * C + c_q);
        end
        relu_val = conv_val[31] ? '0 : conv_val;

        if (state_q == S_POOL) begin
            for (int dr = 0; dr < PS; dr++) begin
                for (int dc = 0; dc < PS; dc++) begin
                    cm_rd = CM_W'(f_q * CC + (r_q * PS + dr) * C + c_q * PS + dc);
                    if ((dr == 0 && dc == 0) || (conv_mem_q[cm_rd] > pool_max))
                        pool_max = conv_mem_q[cm_rd];
                end
            end
        end

        if (fc_mac) begin
            mul_a = pool_mem_q[PM_W'(idx_q)];
            mul_b = bus.fully_connected_layer_weights[J_W'(f_q)][PM_W'(idx_q)];
        end
        if ((state_q == S_FC) && !fc_mac)
            fc_val = scaled + bus.fully_connected_layer_bias[J_W'(f_q)];

        prod = 64'(mul_a) * 64'(mul_b);
    end

    assign conv_done = conv_fin && (f_q == NF - 1) && (r_q == C - 1) && (c_q == C - 1);
    assign pool_done = (state_q == S_POOL) && (idx_q == N - 1);
    assign fc_done   = (state_q == S_FC) && !fc_mac && (f_q == NL - 1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_CONV;
            S_CONV:  if (conv_done) state_d = S_POOL;
            S_POOL:  if (pool_done) state_d = S_FC;
            S_FC:    if (fc_done) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q <= S_IDLE;
            f_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            kr_q    <= '0;
            kc_q    <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            for (int j = 0; j < NL; j++) out_q[j] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_CONV: begin
                    if (conv_mac) begin
                        acc_q <= acc_q + prod;
                        if (kc_q == K - 1) begin
                            kc_q <= '0;
                            kr_q <= kr_q + 1;
                        end else begin
                            kc_q <= kc_q + 1;
                        end
                    end else begin
                        acc_q <= '0;
                        kr_q  <= '0;
                        kc_q  <= '0;
                        if (c_q == C - 1) begin
                            c_q <= '0;
                            if (r_q == C - 1) begin
                                r_q <= '0;
                                f_q <= (f_q == NF - 1) ? '0 : f_q + 1;
                            end else begin
                                r_q <= r_q + 1;
                            end
                        end else begin
                            c_q <= c_q + 1;
                        end
                    end
                end
                S_POOL: begin
                    idx_q <= pool_done ? '0 : idx_q + 1;
                    if (c_q == P - 1) begin
                        c_q <= '0;
                        if (r_q == P - 1) begin
                            r_q <= '0;
                            f_q <= (f_q == NF - 1) ? '0 : f_q + 1;
                        end else begin
                            r_q <= r_q + 1;
                        end
                    end else begin
                        c_q <= c_q + 1;
                    end
                end
                S_FC: begin
                    if (fc_mac) begin
                        acc_q <= acc_q + prod;
                        idx_q <= idx_q + 1;
                    end else begin
                        out_q[J_W'(f_q)] <= fc_val;
                        acc_q            <= '0;
                        idx_q            <= '0;
                        f_q              <= f_q + 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Scratch memories carry no reset: every entry is rewritten before it is
    // read in each run.
    always_ff @(posedge clk) begin
        if (!rstb && conv_fin)
            conv_mem_q[cm_wr] <= relu_val;
        if (!rstb && (state_q == S_POOL))
            pool_mem_q[PM_W'(idx_q)] <= pool_max;
    end

    always_comb begin
        for (int j = 0; j < NL; j++) bus.fully_connected_layer_output[j] = out_q[j];
    end

    assign state_o = state_q;
endmodule

// File: tb/tb_cnn_core.sv
// ---------------------------------------------------------------------------
// tb_cnn_core
// Directed self-checking bench for cnn_core on a reduced geometry so that
// each full inference is a few hundred cycles:
//   9x9 image, 3x3 kernel, stride 2, 2 filters, 2x2 pool, 4 FC outputs
//   -> C = 4, P = 2, N = 8.
// Expected scores are hand-derived for this geometry.
// ---------------------------------------------------------------------------
module tb_cnn_core;
    localparam int IS = 9;
    localparam int K  = 3;
    localparam int S  = 2;
    localparam int NF = 2;
    localparam int PS = 2;
    localparam int NL = 4;
    localparam int C  = (IS - K) / S + 1;
    localparam int P  = (C - PS) / PS + 1;
    localparam int N  = NF * P * P;
    // IDLE + CONV + POOL + FC cycles from reset release to DONE (365 here).
    localparam int RUN_CYCLES = 1 + NF * C * C * (K * K + 1) + N + NL * (N + 1);

    localparam logic [31:0] ONE      = 32'h0001_0000;
    localparam logic [2:0]  ST_IDLE  = 3'd0;
    localparam logic [2:0]  ST_DONE  = 3'd4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rstb = 1'b1;
    logic [2:0] state;

    always #5 clk = ~clk;

    cnn_core_if #(
        .input_size                 (IS),
        .conv_filter_size           (K),
        .conv_num_filters           (NF),
        .fully_connected_num_layers (NL),
        .fc_num_inputs              (N)
    ) bus ();

    cnn_core #(
        .input_size                 (IS),
        .conv_filter_size           (K),
        .conv_num_filters           (NF),
        .conv_stride                (S),
        .pooling_size               (PS),
        .fully_connected_num_layers (NL)
    ) dut (
        .clk     (clk),
        .rstb    (rstb),
        .bus     (bus),
        .state_o (state)
    );

    // ---------------- scoreboard ----------------
    int          vec_cnt     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    int          cycles;
    bit          early_update;

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        for (int i = 0; i < IS * IS; i++) bus.input_data[i] = '0;
        for (int f = 0; f < NF; f++) begin
            bus.cnn_filter_bias[f] = '0;
            for (int t = 0; t < K * K; t++) bus.conv_filter_weight[f][t] = '0;
        end
        for (int j = 0; j < NL; j++) begin
            bus.fully_connected_layer_bias[j] = '0;
            for (int i = 0; i < N; i++) bus.fully_connected_layer_weights[j][i] = '0;
        end
    endtask

    task automatic random_inputs();
        for (int i = 0; i < IS * IS; i++) bus.input_data[i] = $urandom;
        for (int f = 0; f < NF; f++) begin
            bus.cnn_filter_bias[f] = $urandom;
            for (int t = 0; t < K * K; t++) bus.conv_filter_weight[f][t] = $urandom;
        end
        for (int j = 0; j < NL; j++) begin
            bus.fully_connected_layer_bias[j] = $urandom;
            for (int i = 0; i < N; i++) bus.fully_connected_layer_weights[j][i] = $urandom;
        end
    endtask

    task automatic setup_all_ones_fc();
        clear_inputs();
        for (int i = 0; i < IS * IS; i++) bus.input_data[i] = ONE;
        for (int f = 0; f < NF; f++) bus.cnn_filter_bias[f] = ONE;
        for (int j = 0; j < NL; j++)
            for (int i = 0; i < N; i++) bus.fully_connected_layer_weights[j][i] = ONE;
    endtask

    task automatic hold_reset(input int n);
        @(negedge clk);
        rstb = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Releases reset at a falling edge and counts rising edges until DONE,
    // bounded; also notes any score change seen during CONV or POOL.
    task automatic run_to_done(output int n_cycles, output bit early);
        rstb     = 1'b0;
        n_cycles = 0;
        early    = 1'b0;
        while (n_cycles < RUN_CYCLES + 50) begin
            @(posedge clk);
            n_cycles++;
            @(negedge clk);
            if (state == ST_DONE) break;
            if (state == 3'd1 || state == 3'd2)
                for (int j = 0; j < NL; j++)
                    if (bus.fully_connected_layer_output[j] !== '0) early = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        random_inputs();
        hold_reset(3);
        vec_cnt++;
        if (state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d expected %0d", state, ST_IDLE);
        end
        for (int j = 0; j < NL; j++) begin
            vec_cnt++;
            if (bus.fully_connected_layer_output[j] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_out[%0d]: got %h expected %h", j,
                         bus.fully_connected_layer_output[j], 32'h0);
            end
        end
    endtask

    task automatic test_const_fc();
        setup_all_ones_fc();
        hold_reset(3);
        run_to_done(cycles, early_update);
        vec_cnt++;
        if (cycles != RUN_CYCLES) begin
            miscompares++;
            $display("FAIL const_fc_latency: got %0d expected %0d", cycles, RUN_CYCLES);
        end
        vec_cnt++;
        if (early_update !== 1'b0) begin
            miscompares++;
            $display("FAIL const_fc_early_update: got %0b expected 0", early_update);
        end
        for (int j = 0; j < NL; j++) exp_q.push_back(32'h0008_0000);
        for (int j = 0; j < NL; j++) begin
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (bus.fully_connected_layer_output[j] !== exp_v) begin
                miscompares++;
                $display("FAIL const_fc_out[%0d]: got %h expected %h", j,
                         bus.fully_connected_layer_output[j], exp_v);
            end
        end
    endtask

    task automatic test_done_hold();
        repeat (20) @(negedge clk);
        vec_cnt++;
        if (state !== ST_DONE) begin
            miscompares++;
            $display("FAIL hold_state: got %0d expected %0d", state, ST_DONE);
        end
        for (int j = 0; j < NL; j++) exp_q.push_back(32'h0008_0000);
        for (int j = 0; j < NL; j++) begin
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (bus.fully_connected_layer_output[j] !== exp_v) begin
                miscompares++;
                $display("FAIL hold_out[%0d]: got %h expected %h", j,
                         bus.fully_connected_layer_output[j], exp_v);
            end
        end
    endtask

    task automatic test_relu_zero();
        random_inputs();
        for (int f = 0; f < NF; f++) begin
            bus.cnn_filter_bias[f] = 32'hFFFF_0000;
            for (int t = 0; t < K * K; t++) bus.conv_filter_weight[f][t] = '0;
        end
        for (int j = 0; j < NL; j++) bus.fully_connected_layer_bias[j] = 32'(j) << 16;
        hold_reset(3);
        run_to_done(cycles, early_update);
        for (int j = 0; j < NL; j++) exp_q.push_back(32'(j) << 16);
        for (int j = 0; j < NL; j++) begin
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (bus.fully_connected_layer_output[j] !== exp_v) begin
                miscompares++;
                $display("FAIL relu_zero_out[%0d]: got %h expected %h", j,
                         bus.fully_connected_layer_output[j], exp_v);
            end
        end
    endtask

    task automatic test_conv_sum();
        clear_inputs();
        for (int i = 0; i < IS * IS; i++) bus.input_data[i] = ONE;
        for (int f = 0; f < NF; f++)
            for (int t = 0; t < K * K; t++) bus.conv_filter_weight[f][t] = ONE;
        bus.fully_connected_layer_weights[0][0] = ONE;
        hold_reset(3);
        run_to_done(cycles, early_update);
        exp_q.push_back(32'h0009_0000);
        for (int j = 1; j < NL; j++) exp_q.push_back(32'h0);
        for (int j = 0; j < NL; j++) begin
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (bus.fully_connected_layer_output[j] !== exp_v) begin
                miscompares++;
                $display("FAIL conv_sum_out[%0d]: got %h expected %h", j,
                         bus.fully_connected_layer_output[j], exp_v);
            end
        end
    endtask

    task automatic test_single_tap();
        clear_inputs();
        bus.input_data[0]            = ONE;
        bus.conv_filter_weight[0][0] = ONE;
        for (int j = 0; j < NL; j++) bus.fully_connected_layer_weights[j][0] = 32'h0002_0000;
        hold_reset(3);
        run_to_done(cycles, early_update);
        for (int j = 0; j < NL; j++) exp_q.push_back(32'h0002_0000);
        for (int j = 0; j < NL; j++) begin
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (bus.fully_connected_layer_output[j] !== exp_v) begin
                miscompares++;
                $display("FAIL single_tap_out[%0d]: got %h expected %h", j,
                         bus.fully_connected_layer_output[j], exp_v);
            end
        end
    endtask

    // Filter 0: 2.0 * -1.5 + 0.25 = -2.75 -> ReLU 0.
    // Filter 1: 2.0 * 0.5 - 0.25 = 0.75.
    // out0 = 4 * 0.75 * -2.0 + 1.0 = -5.0; out1 = sum of filter-0 zeros + 3.0.
    task automatic test_signed();
        clear_inputs();
        for (int i = 0; i < IS * IS; i++) bus.input_data[i] = 32'h0002_0000;
        bus.conv_filter_weight[0][0] = 32'hFFFE_8000;
        bus.cnn_filter_bias[0]       = 32'h0000_4000;
        bus.conv_filter_weight[1][0] = 32'h0000_8000;
        bus.cnn_filter_bias[1]       = 32'hFFFF_C000;
        for (int i = 0; i < N; i++) bus.fully_connected_layer_weights[0][i] = 32'hFFFE_0000;
        bus.fully_connected_layer_bias[0] = ONE;
        for (int i = 0; i < N / 2; i++) bus.fully_connected_layer_weights[1][i] = ONE;
        bus.fully_connected_layer_bias[1] = 32'h0003_0000;
        hold_reset(3);
        run_to_done(cycles, early_update);
        exp_q.push_back(32'hFFFB_0000);
        exp_q.push_back(32'h0003_0000);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        for (int j = 0; j < NL; j++) begin
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (bus.fully_connected_layer_output[j] !== exp_v) begin
                miscompares++;
                $display("FAIL signed_out[%0d]: got %h expected %h", j,
                         bus.fully_connected_layer_output[j], exp_v);
            end
        end
    endtask

    // pixel (r,c) = r*9+c; filter 0 picks tap (0,0) so conv(r,c) = 18r+2c.
    // Pool maxima: 20, 24, 56, 60; FC is identity on the first four inputs.
    task automatic test_max_pool();
        clear_inputs();
        for (int i = 0; i < IS * IS; i++) bus.input_data[i] = 32'(i) << 16;
        bus.conv_filter_weight[0][0] = ONE;
        for (int j = 0; j < NL; j++) bus.fully_connected_layer_weights[j][j] = ONE;
        hold_reset(3);
        run_to_done(cycles, early_update);
        exp_q.push_back(32'h0014_0000);
        exp_q.push_back(32'h0018_0000);
        exp_q.push_back(32'h0038_0000);
        exp_q.push_back(32'h003C_0000);
        for (int j = 0; j < NL; j++) begin
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (bus.fully_connected_layer_output[j] !== exp_v) begin
                miscompares++;
                $display("FAIL max_pool_out[%0d]: got %h expected %h", j,
                         bus.fully_connected_layer_output[j], exp_v);
            end
        end
    endtask

    // 350 edges after release: FC outputs 0 and 1 are finalized, 2 and 3 not.
    task automatic test_mid_reset();
        setup_all_ones_fc();
        hold_reset(3);
        rstb = 1'b0;
        repeat (350) @(posedge clk);
        @(negedge clk);
        exp_q.push_back(32'h0008_0000);
        exp_q.push_back(32'h0008_0000);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        for (int j = 0; j < NL; j++) begin
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (bus.fully_connected_layer_output[j] !== exp_v) begin
                miscompares++;
                $display("FAIL partial_fc_out[%0d]: got %h expected %h", j,
                         bus.fully_connected_layer_output[j], exp_v);
            end
        end
        rstb = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL abort_state: got %0d expected %0d", state, ST_IDLE);
        end
        for (int j = 0; j < NL; j++) begin
            vec_cnt++;
            if (bus.fully_connected_layer_output[j] !== 32'h0) begin
                miscompares++;
                $display("FAIL abort_out[%0d]: got %h expected %h", j,
                         bus.fully_connected_layer_output[j], 32'h0);
            end
        end
        run_to_done(cycles, early_update);
        vec_cnt++;
        if (cycles != RUN_CYCLES) begin
            miscompares++;
            $display("FAIL rerun_latency: got %0d expected %0d", cycles, RUN_CYCLES);
        end
        for (int j = 0; j < NL; j++) exp_q.push_back(32'h0008_0000);
        for (int j = 0; j < NL; j++) begin
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (bus.fully_connected_layer_output[j] !== exp_v) begin
                miscompares++;
                $display("FAIL rerun_out[%0d]: got %h expected %h", j,
                         bus.fully_connected_layer_output[j], exp_v);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        clear_inputs();
        test_reset();
        test_const_fc();
        test_done_hold();
        test_relu_zero();
        test_conv_sum();
        test_single_tap();
        test_signed();
        test_max_pool();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end
endmodule

// File: doc/cnn_core.md
CNN_CORE -- requirements
Module: cnn_core

Interface
REQ-001 Parameter input_size, 28, square input image side length in pixels.
REQ-002 Parameter conv_filter_size, 7, square convolution kernel side.
REQ-003 Parameter conv_num_filters, 16, number of convolution filters.
REQ-004 Parameter conv_stride, 3, convolution stride, both axes.
REQ-005 Parameter pooling_size, 2, max-pool window side, equal to the pool stride.
REQ-006 Parameter fully_connected_num_layers, 10, number of fully connected outputs.
REQ-007 Derived values: C = (input_size-conv_filter_size)/conv_stride+1 (8), P = (C-pooling_size)/pooling_size+1 (4), N = conv_num_filters*P*P (256).
REQ-008 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-009 Port rstb, input, 1: one clock; reset is synchronous and active-high.
REQ-010 Port input_data, input, 32 x input_size^2 (unpacked): pixel (r,c) at index r*input_size+c.
REQ-011 Port conv_filter_weight, input, 32 x [conv_num_filters][K*K]: filter f, tap (kr,kc) at [f][kr*K+kc], where K = conv_filter_size.
REQ-012 Port cnn_filter_bias, input, 32 x [conv_num_filters]: per-filter bias.
REQ-013 Port fully_connected_layer_weights, input, 32 x [fully_connected_num_layers][N]: weight j,i at [j][i].
REQ-014 Port fully_connected_layer_bias, input, 32 x [fully_connected_num_layers]: per-output bias.
REQ-015 Port fully_connected_layer_output, output, 32 x [fully_connected_num_layers]: registered class scores.

Function
REQ-016 All data words, weights, biases and outputs shall be signed two's-complement Q16.16 (1.0 = 0x00010000).
REQ-017 Conv output (f,r,c) shall be the sum over kr,kc of input[(r*S+kr)*input_size+(c*S+kc)] * weight[f][kr*K+kc], where S = conv_stride; the 64-bit sum of products is arithmetic-shifted right 16, truncated to 32 bits, plus cnn_filter_bias[f], with modulo-2^32 wrap.
REQ-018 ReLU shall apply to each conv output: negative becomes 0, otherwise unchanged.
REQ-019 Pooled (f,pr,pc) shall be the signed max of the ReLU outputs in the non-overlapping 2x2 window at rows 2pr..2pr+1 and columns 2pc..2pc+1.
REQ-020 Flatten index shall be i = f*P*P + pr*P + pc.
REQ-021 FC output j shall be the sum over i of pooled[i]*W[j][i], accumulated at 64 bits, then shifted >>>16, truncated to 32 bits, plus bias[j] (wrap); no activation on the FC outputs.
REQ-022 FSM states IDLE -> CONV -> POOL -> FC -> DONE; IDLE lasts one cycle after reset release.
REQ-023 CONV: one MAC per cycle, plus one finalize cycle (bias, ReLU, store) per conv output; 50 cycles per output, 16*64 outputs, filter-major then row then column.
REQ-024 POOL: one pooled value per cycle (256 cycles).
REQ-025 FC: one MAC per cycle, plus one finalize cycle per output (257 cycles per output).
REQ-026 Each FC output register shall update only at its finalize cycle.
REQ-027 All outputs shall be final no later than 54100 cycles after rstb deasserts.
REQ-028 DONE shall hold all outputs stable indefinitely; no recomputation occurs until the next reset.
REQ-029 Inputs shall be sampled during computation; the bench holds them stable from reset release to DONE.

Reset
REQ-030 While rstb=1 at a rising edge: FSM to IDLE, all counters and accumulators cleared, every fully_connected_layer_output = 0x00000000.
REQ-031 Reset asserted mid-operation shall abort the computation, zero all outputs, and restart from IDLE after release.

Verification
REQ-032 rstb=1 for 3 cycles, any inputs -> all 10 outputs 0x00000000.
REQ-033 Input all 1.0, conv weights 0, conv bias 1.0, FC weights all 1.0, FC bias 0 -> every output 0x01000000 (256.0) after DONE.
REQ-034 Conv weights 0, conv bias -1.0 (0xFFFF0000), FC bias[j] = j*1.0 -> ReLU zeros, output j = j<<16 (e.g. output 9 = 0x00090000).
REQ-035 Input all 1.0, conv weights all 1.0, bias 0, FC weights with W[0][0]=1.0 else 0, FC bias 0 -> output 0 = 0x00310000 (49.0), outputs 1..9 = 0.
REQ-036 Only pixel (0,0)=1.0, only weight[0][0]=1.0, W[j][0]=2.0 else 0, all biases 0 -> every output 0x00020000.
REQ-037 Scenario REQ-033 with rstb pulsed high at cycle 1000 for 1 cycle -> outputs 0 immediately, then 0x01000000 after a full rerun.
